// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer
// Host-side command engine in front of a tpuv1 core. One job does the following:
//   1. Streams DIM rows of A, then DIM rows of B, from the input stream into the core.
//   2. Optionally zeroes the C accumulators.
//   3. Fires the start command and waits out the fixed systolic latency.
//   4. Reads every C half-row back onto a valid/ready output stream.
//
// Stream handshakes: a word moves on a stream in a cycle where both valid and
// ready are high at the rising clock edge. A producer that raises valid keeps
// valid and data unchanged until that happens. The ready signal may change
// freely and never depends combinationally on valid.
//
// TPU bus: addr / r_w / wdata are registered. Any cycle that carries no command
// shows addr=0, r_w=0, wdata=0. Read data is combinational from addr.
module tpu_job_sequencer #(
   parameter int DIM            = 8,
   parameter int BITS_C         = 16,
   parameter int ADDRW          = 16,
   parameter int DATAW          = 64,
   parameter int COMPUTE_CYCLES = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_start,
   input  logic             clr_c,
   output logic             job_busy,
   output logic             job_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic [ADDRW-1:0] tpu_addr,
   output logic             tpu_r_w,
   output logic [DATAW-1:0] tpu_wdata,
   input  logic [DATAW-1:0] tpu_rdata
);

   // Counter widths. Every counter restarts from zero on each job, so none wraps.
   localparam int ROWW  = $clog2(DIM) + 1;
   localparam int IDXW  = $clog2(2 * DIM) + 1;
   localparam int WAITW = $clog2(COMPUTE_CYCLES) + 1;

   // tpuv1 address map
   localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(16'h0100);
   localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(16'h0200);
   localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(16'h0300);
   localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);

   // One C row is exactly two bus words. The drain needs the full systolic depth.
   if (DIM * BITS_C != 2 * DATAW) begin : g_bad_c_width
      $error("tpu_job_sequencer: DIM*BITS_C must equal 2*DATAW");
   end
   if (COMPUTE_CYCLES < 3 * DIM + 1) begin : g_bad_latency
      $error("tpu_job_sequencer: COMPUTE_CYCLES must be >= 3*DIM+1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_CLR_C  = 3'd3,
      S_START  = 3'd4,
      S_WAIT   = 3'd5,
      S_READ_C = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [ROWW-1:0]   row_q, row_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WAITW-1:0]  wait_q, wait_d;
   logic              clr_q, clr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ov_q, ov_d;
   logic [DATAW-1:0]  od_q, od_d;
   logic [ADDRW-1:0]  addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [DATAW-1:0]  wdata_q, wdata_d;

   logic              loading;
   logic              in_hs;
   logic              out_hs;
   logic              cap;
   logic              last_row;
   logic              last_idx;

   // Rows and C words sit 8 bytes apart; C row r half h is word slot 2r+h.
   function automatic logic [ADDRW-1:0] slot_addr(input logic [ADDRW-1:0] base,
                                                  input logic [ADDRW-1:0] slot);
      slot_addr = base + (slot << 3);
   endfunction

   // Input is accepted only while A or B is streaming in.
   // in_ready therefore falls in the cycle after the final B handshake.
   assign loading  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign in_hs    = loading && in_valid;
   assign out_hs   = ov_q && out_ready;
   // The output register can take a new C word when it is empty or draining this cycle.
   assign cap      = (state_q == S_READ_C) && (!ov_q || out_ready);
   assign last_row = (row_q == ROWW'(DIM - 1));
   assign last_idx = (idx_q == IDXW'(2 * DIM - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: job_start is looked at only in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (job_start) state_d = S_LOAD_A;
         S_LOAD_A: if (in_hs && last_row) state_d = S_LOAD_B;
         S_LOAD_B: if (in_hs && last_row) state_d = clr_q ? S_CLR_C : S_START;
         S_CLR_C:  if (last_idx) state_d = S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT:   if (wait_q == '0) state_d = S_READ_C;
         S_READ_C: if (cap && last_idx) state_d = S_DONE;
         S_DONE:   if (out_hs) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output/datapath logic: the next bus command, counters and the C output register.
   always_comb begin
      row_d   = row_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      clr_d   = clr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ov_d    = ov_q && !out_ready;
      od_d    = od_q;
      addr_d  = '0;
      rw_d    = 1'b0;
      wdata_d = '0;
      case (state_q)
         S_IDLE: begin
            if (job_start) begin
               clr_d  = clr_c;
               busy_d = 1'b1;
               row_d  = '0;
               idx_d  = '0;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            // One row write per accepted word. A gap in in_valid leaves the bus idle.
            if (in_hs) begin
               addr_d  = slot_addr((state_q == S_LOAD_A) ? A_BASE : B_BASE, ADDRW'(row_q));
               rw_d    = 1'b1;
               wdata_d = in_data;
               row_d   = last_row ? '0 : row_q + ROWW'(1);
            end
         end
         S_CLR_C: begin
            // Zero every C half-row back to back, in row-major order.
            addr_d = slot_addr(C_BASE, ADDRW'(idx_q));
            rw_d   = 1'b1;
            idx_d  = last_idx ? '0 : idx_q + IDXW'(1);
         end
         S_START: begin
            addr_d = START_ADDR;
            wait_d = WAITW'(COMPUTE_CYCLES);
         end
         S_WAIT: begin
            // Put the first C address on the bus as the wait ends.
            // Its read data is then already valid in the first READ_C cycle.
            if (wait_q == '0) begin
               addr_d = C_BASE;
            end else begin
               wait_d = wait_q - WAITW'(1);
            end
         end
         S_READ_C: begin
            if (cap) begin
               od_d = tpu_rdata;
               ov_d = 1'b1;
               if (last_idx) begin
                  idx_d = '0;
               end else begin
                  idx_d  = idx_q + IDXW'(1);
                  addr_d = slot_addr(C_BASE, ADDRW'(idx_q) + ADDRW'(1));
               end
            end else begin
               // Backpressure: keep presenting the same C address.
               addr_d = addr_q;
            end
         end
         S_DONE: begin
            if (out_hs) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         row_q   <= row_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         clr_q   <= clr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
      end
   end

   assign in_ready  = loading;
   assign job_busy  = busy_q;
   assign job_done  = done_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign tpu_addr  = addr_q;
   assign tpu_r_w   = rw_q;
   assign tpu_wdata = wdata_q;

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb_tpu_job_sequencer
// Random matrix jobs through tpu_job_sequencer, with a memory-level tpuv1 responder.
// Expected C words come from a matrix-level reference: C = (clr ? 0 : C) + A x B.
module tb_tpu_job_sequencer;

   localparam int DIM = 8;
   localparam int NW  = 2 * DIM;
   localparam int CC  = 26;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_start = 1'b0;
   logic        clr_c = 1'b0;
   logic        job_busy, job_done;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [15:0] tpu_addr;
   logic        tpu_r_w;
   logic [63:0] tpu_wdata;
   logic [63:0] tpu_rdata;

   always #5 clk = ~clk;

   tpu_job_sequencer #(
      .DIM(DIM), .BITS_C(16), .ADDRW(16), .DATAW(64), .COMPUTE_CYCLES(CC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .job_start(job_start), .clr_c(clr_c),
      .job_busy(job_busy), .job_done(job_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata),
      .tpu_rdata(tpu_rdata)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q[$];      // expected C words, in output order
   logic [63:0] in_q[$];       // words still to be offered on the input stream
   logic [15:0] exp_wr_a[$];   // expected bus writes: address
   logic [63:0] exp_wr_d[$];   // expected bus writes: data

   int am[DIM][DIM];
   int bm[DIM][DIM];
   int c_ref[DIM][DIM] = '{default: 0};

   // tpuv1 responder storage
   logic [63:0] a_mem[DIM] = '{default: '0};
   logic [63:0] b_mem[DIM] = '{default: '0};
   logic [63:0] c_mem[NW]  = '{default: '0};

   int          done_cnt = 0;
   int          start_cnt = 0;
   int          idle_run = 0;
   bit          in_wait = 1'b0;
   logic [15:0] mon_ea;
   logic [63:0] mon_ed;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- tpuv1 responder ----------------
   always_comb begin
      tpu_rdata = '0;
      if (tpu_addr[15:7] == 9'h006 && tpu_addr[2:0] == 3'b000) tpu_rdata = c_mem[tpu_addr[6:3]];
   end

   task automatic tpu_compute();
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < DIM; k++)
               s += int'(a_mem[i][8*k +: 8]) * int'(b_mem[k][8*j +: 8]);
            c_mem[2*i + j/4][16*(j%4) +: 16] = c_mem[2*i + j/4][16*(j%4) +: 16] + 16'(s);
         end
      end
   endtask

   // Bus monitor + responder update, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (job_done) done_cnt++;
         if (tpu_r_w) begin
            mon_ea = 16'hffff;
            mon_ed = '0;
            if (exp_wr_a.size() > 0) begin
               mon_ea = exp_wr_a.pop_front();
               mon_ed = exp_wr_d.pop_front();
            end
            check("bus_wr_addr", 64'(tpu_addr), 64'(mon_ea));
            check("bus_wr_data", tpu_wdata, mon_ed);
            if (tpu_addr[15:6] == 10'h004)      a_mem[tpu_addr[5:3]] = tpu_wdata;
            else if (tpu_addr[15:6] == 10'h008) b_mem[tpu_addr[5:3]] = tpu_wdata;
            else if (tpu_addr[15:7] == 9'h006)  c_mem[tpu_addr[6:3]] = tpu_wdata;
         end else if (tpu_addr == 16'h0400) begin
            check("start_after_writes", 64'(exp_wr_a.size()), 64'd0);
            tpu_compute();
            start_cnt++;
            idle_run = 0;
            in_wait  = 1'b1;
         end else if (tpu_addr == 16'h0000) begin
            if (in_wait) idle_run++;
         end else if (tpu_addr[15:7] == 9'h006 && tpu_addr[2:0] == 3'b000) begin
            if (in_wait) begin
               check("wait_idle_cycles", 64'(idle_run), 64'(CC));
               in_wait = 1'b0;
            end
         end else begin
            check("bus_addr_legal", 64'(tpu_addr), 64'd0);
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic rand_mats();
      for (int i = 0; i < DIM; i++)
         for (int k = 0; k < DIM; k++) begin
            am[i][k] = int'($urandom_range(0, 255));
            bm[i][k] = int'($urandom_range(0, 255));
         end
   endtask

   function automatic logic [63:0] row_word(input bit is_b, input int r);
      logic [63:0] w;
      for (int k = 0; k < DIM; k++) w[8*k +: 8] = is_b ? 8'(bm[r][k]) : 8'(am[r][k]);
      return w;
   endfunction

   // First nwords of the A-then-B stream, and the bus writes they should cause.
   task automatic load_queues(input bit clr, input int nwords);
      in_q.delete();
      exp_wr_a.delete();
      exp_wr_d.delete();
      for (int n = 0; n < nwords; n++) begin
         logic [63:0] w;
         w = row_word(n >= DIM, n % DIM);
         in_q.push_back(w);
         exp_wr_a.push_back(16'((n < DIM) ? 16'h0100 : 16'h0200) + 16'(8 * (n % DIM)));
         exp_wr_d.push_back(w);
      end
      if (clr && nwords == NW)
         for (int w = 0; w < NW; w++) begin
            exp_wr_a.push_back(16'h0300 + 16'(8 * w));
            exp_wr_d.push_back('0);
         end
   endtask

   task automatic ref_job(input bit clr);
      exp_q.delete();
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            int s;
            s = clr ? 0 : c_ref[i][j];
            for (int k = 0; k < DIM; k++) s += am[i][k] * bm[k][j];
            c_ref[i][j] = s % 65536;
         end
      for (int w = 0; w < NW; w++) begin
         logic [63:0] v;
         for (int l = 0; l < 4; l++) v[16*l +: 16] = 16'(c_ref[w/2][4*(w%2) + l]);
         exp_q.push_back(v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input bit clr);
      @(negedge clk);
      job_start = 1'b1;
      clr_c     = clr;
      @(negedge clk);
      job_start = 1'b0;
      clr_c     = 1'b0;
      check("busy_after_start", 64'(job_busy), 64'd1);
   endtask

   // mode 0 = full rate, 1 = toggle every cycle, 2 = random gaps
   task automatic drive_inputs(input int mode, input bit expect_drop);
      int guard;
      bit tog;
      guard = 0;
      tog   = 1'b0;
      while (in_q.size() > 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
         case (mode)
            0:       in_valid = 1'b1;
            1:       begin tog = !tog; in_valid = tog; end
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         in_data = in_valid ? in_q[0] : {$urandom, $urandom};
         if (in_valid && in_ready) void'(in_q.pop_front());
      end
      if (in_q.size() > 0) check("in_timeout", 64'(in_q.size()), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      if (expect_drop) check("in_ready_drop", 64'(in_ready), 64'd0);
   endtask

   // mode 0 = always ready, 1 = random, 2 = 5-cycle stall on the third word
   task automatic consume(input int mode);
      int          got, guard, stall;
      bit          prev_stall;
      logic [63:0] prev_d, e;
      logic [15:0] prev_a;
      got = 0; guard = 0; stall = 0; prev_stall = 1'b0; prev_d = '0; prev_a = '0;
      while (got < NW && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, prev_d);
            check("hold_addr", 64'(tpu_addr), 64'(prev_a));
         end
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 1) == 1);
            default: begin
               if (got == 2 && out_valid && stall < 5) begin
                  out_ready = 1'b0;
                  stall++;
                  check("stall_addr", 64'(tpu_addr), 64'h318);
               end else begin
                  out_ready = 1'b1;
               end
            end
         endcase
         if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead_beef_dead_beef;
            check("c_word", out_data, e);
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_a     = tpu_addr;
      end
      if (got < NW) check("out_timeout", 64'(got), 64'(NW));
   endtask

   // Pulse job_start once the job sits in its compute wait.
   task automatic poke_wait(input int s0);
      int guard;
      guard = 0;
      while (start_cnt == s0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("poke_saw_start", 64'(start_cnt - s0), 64'd1);
      repeat (5) @(negedge clk);
      job_start = 1'b1;
      clr_c     = 1'b1;
      @(negedge clk);
      job_start = 1'b0;
      clr_c     = 1'b0;
      check("busy_in_wait", 64'(job_busy), 64'd1);
   endtask

   task automatic run_job(input bit clr, input int in_mode, input int out_mode, input bit poke);
      int d0, s0;
      load_queues(clr, NW);
      ref_job(clr);
      d0 = done_cnt;
      s0 = start_cnt;
      pulse_start(clr);
      fork
         drive_inputs(in_mode, 1'b1);
         consume(out_mode);
         begin
            if (poke) poke_wait(s0);
         end
      join
      repeat (2) @(negedge clk);
      check("job_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("busy_after_done", 64'(job_busy), 64'd0);
      check("start_cmds", 64'(start_cnt - s0), 64'd1);
      check("writes_left", 64'(exp_wr_a.size()), 64'd0);
      check("words_left", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   64'(job_busy),  64'd0);
      check({tag, "_done"},   64'(job_done),  64'd0);
      check({tag, "_inrdy"},  64'(in_ready),  64'd0);
      check({tag, "_oval"},   64'(out_valid), 64'd0);
      check({tag, "_odata"},  out_data,       64'd0);
      check({tag, "_addr"},   64'(tpu_addr),  64'd0);
      check({tag, "_rw"},     64'(tpu_r_w),   64'd0);
      check({tag, "_wdata"},  tpu_wdata,      64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Job 1: identity A, every B row = 0x0807060504030201.
      for (int i = 0; i < DIM; i++)
         for (int k = 0; k < DIM; k++) begin
            am[i][k] = (i == k) ? 1 : 0;
            bm[i][k] = k + 1;
         end
      run_job(1'b0, 0, 0, 1'b0);

      // Job 2: random data, C cleared first.
      rand_mats();
      run_job(1'b1, 0, 0, 1'b0);

      // Job 3: toggling input, output stall at the third word, accumulate onto C.
      rand_mats();
      run_job(1'b0, 1, 2, 1'b0);

      // Job 4: random gaps both sides, job_start poked during the wait.
      rand_mats();
      run_job(1'b1, 2, 1, 1'b1);

      // Job 5: reset asserted part-way through LOAD_B.
      rand_mats();
      load_queues(1'b0, DIM + 4);
      pulse_start(1'b0);
      drive_inputs(0, 1'b0);
      check("abort_in_load_b", 64'(in_ready), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      in_q.delete();
      exp_wr_a.delete();
      exp_wr_d.delete();
      repeat (3) @(negedge clk);
      check_reset_outputs("midrst_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Job 6: a fresh job after the abort.
      rand_mats();
      run_job(1'b1, 2, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
- Host-side command engine directly upstream of the TPU core (tpuv1 bus: addr/r_w/dataIn/dataOut).
- Takes one matrix job as a 64-bit word stream (DIM A rows, then DIM B rows) and writes those rows into the core.
- Optionally zeroes C, triggers compute and waits the fixed systolic latency.
- Reads back all C words and emits them on a valid/ready output stream.

Parameters:
- DIM, 8, matrix dimension; rows per A/B load and C rows read.
- BITS_C, 16, C element width; DIM*BITS_C must equal 2*DATAW.
- ADDRW, 16, TPU address width.
- DATAW, 64, word width for streams and TPU bus.
- COMPUTE_CYCLES, 26, wait cycles after the start command; must be >= 3*DIM+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  one-cycle pulse; begins a job when idle
- clr_c  in  1  sampled with job_start; 1 = zero C before compute
- job_busy  out  1  high from accepted job_start until job_done
- job_done  out  1  one-cycle pulse after the last C word handshake
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer accepts an input word
- in_data  in  DATAW  A/B row word; byte i = element i
- out_valid  out  1  C word valid
- out_ready  in  1  downstream accepts the C word
- out_data  out  DATAW  C word; 16-bit lane j = element j of that half-row
- tpu_addr  out  ADDRW  TPU address, registered
- tpu_r_w  out  1  1 = write, 0 = read, registered
- tpu_wdata  out  DATAW  TPU write data, registered
- tpu_rdata  in  DATAW  TPU read data; combinational from tpu_addr

Behaviour:
- Reset values: job_busy=0, job_done=0, in_ready=0, out_valid=0, out_data=0, tpu_addr=0, tpu_r_w=0, tpu_wdata=0, FSM=IDLE, all counters 0.
- Idle bus: tpu_addr=0x000, tpu_r_w=0. The bus returns to idle every cycle in which no command is issued.
- Address map:
  - A row r = 0x100 + 8r.
  - B row r = 0x200 + 8r.
  - C row r, half h = 0x300 + 16r + 8h.
  - Start = 0x400.
- FSM states: IDLE, LOAD_A, LOAD_B, CLR_C, START, WAIT, READ_C, DONE.
- IDLE:
  - job_start=1 latches clr_c, sets job_busy and moves to LOAD_A.
  - job_start is ignored in every other state.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - Each in_valid&&in_ready handshake registers a write on the next cycle: tpu_addr=row address, tpu_r_w=1, tpu_wdata=in_data.
  - The row counter increments per handshake, one write per cycle maximum.
  - Gaps in in_valid produce idle bus cycles.
  - After DIM handshakes, LOAD_A moves to LOAD_B. After DIM handshakes, LOAD_B moves to CLR_C if clr_c was latched, otherwise to START.
  - in_ready drops in the cycle after the final B handshake.
- CLR_C: issues 2*DIM consecutive writes of 0 to C rows 0..DIM-1, halves 0 and 1, one per cycle, row-major, then moves to START.
- START:
  - Issues one cycle at tpu_addr=0x400, tpu_r_w=0.
  - Loads the wait counter with COMPUTE_CYCLES and moves to WAIT.
- WAIT: bus idle; counter decrements each cycle; moves to READ_C when it reaches 0.
- READ_C:
  - Drives the C read address with r_w=0.
  - When the output register is empty or being drained (!out_valid || out_ready), it captures tpu_rdata into out_data, sets out_valid and advances the index.
  - Index order: row 0 h0, row 0 h1, …, row DIM-1 h1.
  - Under backpressure, tpu_addr and out_data hold.
  - Sustained throughput is 1 word/cycle.
- DONE:
  - Entered when the 2*DIM-th word has been captured. Wait for that word's handshake.
  - Then pulse job_done, clear job_busy and return to IDLE.
- out_valid holds until out_ready; out_data is stable while out_valid && !out_ready.
- Reset mid-job: immediate return to reset values. Partial TPU contents are left as is; no words are emitted.
- Counter widths:
  - Row counters: $clog2(DIM)+1 bits.
  - C index: $clog2(2*DIM)+1 bits.
  - Wait counter: $clog2(COMPUTE_CYCLES)+1 bits.
  - No wrap within a job.

Test Plan:
- Full-rate job, clr_c=0, A=identity (byte r of row r = 1), B rows = 0x0807060504030201 → bus shows writes 0x100..0x138, then 0x200..0x238, then one 0x400 cycle and 26 idle cycles. Reads 0x300..0x378 step 8 (16 words) match the TPU model. job_done pulses once.
- clr_c=1 → 16 writes of 0 to 0x300,0x308,…,0x378 between the last B write and 0x400. C read-back equals A×B with no accumulated stale data.
- in_valid toggling 1/0 every cycle during loads → exactly 16 writes, idle cycles in the gaps, addresses unchanged.
- out_ready low for 5 cycles at word 3 → out_data and tpu_addr=0x318 held, no word lost or duplicated, 16 handshakes total.
- job_start pulsed during WAIT → ignored, and job_busy stays 1. rst_n asserted during LOAD_B → all outputs return to reset values within the reset. A new job afterward completes normally.
